des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_key_schedule.sv | 165 ++++++++++++++++
 tb/tb_des_key_schedule.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// DES 16-round key schedule: PC-1 load, per-round C/D rotation, combinational PC-2 output.
// Optional DES_KEY_PARITY_CHECK_EN rejects starts whose key has any even-parity byte.
module des_key_schedule (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_strobe_din,
    input  logic [0:63] key_din,
    input  logic        decrypt_din,
    input  logic        next_round_din,
    output logic [0:47] round_key_dout,
    output logic        round_key_valid_dout,
    output logic [0:3]  round_index_dout,
    output logic        schedule_done_dout,
    output logic        key_parity_error_dout
);

    typedef enum logic {StIdle, StActive} state_e;

    // Table entries are 1-based DES bit numbers.
    localparam int unsigned Pc1Tab [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned Pc2Tab [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit r set when round r+1 rotates by two.
    localparam logic [15:0] ShiftTwo = 16'h7EFC;

    function automatic logic [0:55] pc1(input logic [0:63] k);
        logic [0:55] r;
        for (int i = 0; i < 56; i++) begin
            r[i] = k[Pc1Tab[i] - 1];
        end
        return r;
    endfunction

    function automatic logic [0:47] pc2(input logic [0:55] cd);
        logic [0:47] r;
        for (int i = 0; i < 48; i++) begin
            r[i] = cd[Pc2Tab[i] - 1];
        end
        return r;
    endfunction

    function automatic logic [0:27] rotl(input logic [0:27] v, input logic two);
        return two ? {v[2:27], v[0:1]} : {v[1:27], v[0]};
    endfunction

    function automatic logic [0:27] rotr(input logic [0:27] v, input logic two);
        return two ? {v[26:27], v[0:25]} : {v[27], v[0:26]};
    endfunction

    state_e      state_q, state_d;
    logic [0:27] c_q, c_d, d_q, d_d;
    logic [0:3]  idx_q, idx_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;
    logic        key_ok;
    logic [0:55] cd_load;
    logic [3:0]  idx_fwd, idx_rev;

`ifdef DES_KEY_PARITY_CHECK_EN
    logic perr_q, perr_d;

    always_comb begin
        key_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (!(^key_din[8*b +: 8])) begin
                key_ok = 1'b0;
            end
        end
    end

    always_comb begin
        perr_d = (state_q == StIdle) && start_strobe_din && !key_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign key_parity_error_dout = perr_q;
`else
    assign key_ok                = 1'b1;
    assign key_parity_error_dout = 1'b0;
`endif

    assign cd_load = pc1(key_din);
    assign idx_fwd = idx_q + 4'd1;
    assign idx_rev = 4'd15 - idx_q;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_strobe_din && key_ok) begin
                    // Encrypt preloads the round-1 shift; decrypt starts at C0 = C16.
                    c_d     = decrypt_din ? cd_load[0:27]  : rotl(cd_load[0:27], 1'b0);
                    d_d     = decrypt_din ? cd_load[28:55] : rotl(cd_load[28:55], 1'b0);
                    dec_d   = decrypt_din;
                    idx_d   = 4'd0;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (next_round_din) begin
                    if (idx_q == 4'd15) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_fwd;
                        if (dec_q) begin
                            c_d = rotr(c_q, ShiftTwo[idx_rev]);
                            d_d = rotr(d_q, ShiftTwo[idx_rev]);
                        end else begin
                            c_d = rotl(c_q, ShiftTwo[idx_fwd]);
                            d_d = rotl(d_q, ShiftTwo[idx_fwd]);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    assign round_key_dout       = pc2({c_q, d_q});
    assign round_key_valid_dout = (state_q == StActive);
    assign round_index_dout     = idx_q;
    assign schedule_done_dout   = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a numeric DES key-schedule model.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [0:63] key;
    logic        dec;
    logic        nr;
    logic [0:47] rk;
    logic        rkv;
    logic [0:3]  ridx;
    logic        done;
    logic        perr;

    int errs   = 0;
    int checks = 0;

    logic [47:0] exp_k [16];

    localparam logic [63:0] KeyStd   = 64'h133457799BBCDFF1;
    localparam logic [47:0] KeyK1    = 48'h1B02EFFC7072;
    localparam logic [47:0] KeyK16   = 48'hCB3D8B0E17F5;

    localparam int Pc1 [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int Pc2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int Shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_schedule dut (
        .clk                   (clk),
        .reset                 (reset),
        .start_strobe_din      (start),
        .key_din               (key),
        .decrypt_din           (dec),
        .next_round_din        (nr),
        .round_key_dout        (rk),
        .round_key_valid_dout  (rkv),
        .round_index_dout      (ridx),
        .schedule_done_dout    (done),
        .key_parity_error_dout (perr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Standard key schedule on plain integers; DES bit n of a value is value bit (W - n).
    task automatic compute_keys(input logic [63:0] k, input logic d);
        logic [55:0] cd;
        logic [27:0] c, dd;
        logic [47:0] ks [16];
        for (int i = 0; i < 56; i++) cd[55 - i] = k[64 - Pc1[i]];
        c  = cd[55:28];
        dd = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            c  = 28'((c << Shifts[r]) | (c >> (28 - Shifts[r])));
            dd = 28'((dd << Shifts[r]) | (dd >> (28 - Shifts[r])));
            cd = {c, dd};
            for (int j = 0; j < 48; j++) ks[r][47 - j] = cd[56 - Pc2[j]];
        end
        for (int i = 0; i < 16; i++) exp_k[i] = d ? ks[15 - i] : ks[i];
    endtask

    function automatic logic [63:0] odd_parity(input logic [63:0] k);
        logic [63:0] r = k;
        for (int b = 0; b < 8; b++) r[8*b] = ~^r[8*b+1 +: 7];
        return r;
    endfunction

    function automatic logic [63:0] rand_key();
        return odd_parity({$urandom, $urandom});
    endfunction

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; nr = 1'b0; key = '0; dec = 1'b0;
        tick; tick;
        checks++;
        if ({rkv, done, perr, ridx} !== 7'd0) begin
            errs++; $display("FAIL reset_ctrl: got %b want 0", {rkv, done, perr, ridx});
        end
        checks++;
        if (rk !== 48'd0) begin errs++; $display("FAIL reset_key: got %h want 0", rk); end
        reset = 1'b0;
        tick;
        checks++;
        if ({rkv, rk} !== 49'd0) begin
            errs++; $display("FAIL post_reset: valid=%b key=%h want 0/0", rkv, rk);
        end
    endtask

    task automatic test_idle_ack_ignored;
        nr = 1'b1;
        repeat (3) begin
            tick;
            checks++;
            if ({rkv, done} !== 2'b00) begin
                errs++; $display("FAIL idle_ack: valid/done=%b want 00", {rkv, done});
            end
        end
        nr = 1'b0;
    endtask

    task automatic test_known_vector(input logic d);
        compute_keys(KeyStd, d);
        key = KeyStd; dec = d; start = 1'b1;
        tick;
        start = 1'b0; key = ~KeyStd; dec = ~d;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rkv !== 1'b1 || ridx !== 4'(i) || done !== 1'b0) begin
                errs++;
                $display("FAIL vec%0d_ctrl[%0d]: valid=%b idx=%0d done=%b", d, i, rkv, ridx, done);
            end
            checks++;
            if (rk !== exp_k[i]) begin
                errs++; $display("FAIL vec%0d_key[%0d]: got %h want %h", d, i, rk, exp_k[i]);
            end
            if (i == 0) begin
                checks++;
                if (rk !== (d ? KeyK16 : KeyK1)) begin
                    errs++; $display("FAIL vec%0d_first: got %h", d, rk);
                end
            end
            if (i == 15) begin
                checks++;
                if (rk !== (d ? KeyK1 : KeyK16)) begin
                    errs++; $display("FAIL vec%0d_last: got %h", d, rk);
                end
            end
            nr = 1'b1;
            tick;
        end
        nr = 1'b0;
        checks++;
        if ({done, rkv} !== 2'b10) begin
            errs++; $display("FAIL vec%0d_done: done/valid=%b want 10", d, {done, rkv});
        end
        tick;
        checks++;
        if ({done, rkv} !== 2'b00) begin
            errs++; $display("FAIL vec%0d_done_pulse: done/valid=%b want 00", d, {done, rkv});
        end
    endtask

    task automatic test_hold_restart;
        logic [63:0] k = rand_key();
        compute_keys(k, 1'b0);
        key = k; dec = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin nr = 1'b1; tick; end
        nr = 1'b0; start = 1'b1; key = rand_key(); dec = 1'b1;
        repeat (5) begin
            tick;
            checks++;
            if (rkv !== 1'b1 || ridx !== 4'd3 || rk !== exp_k[3]) begin
                errs++;
                $display("FAIL hold: valid=%b idx=%0d key=%h want 1/3/%h", rkv, ridx, rk, exp_k[3]);
            end
        end
        start = 1'b0;
        for (int i = 3; i < 16; i++) begin
            checks++;
            if (ridx !== 4'(i) || rk !== exp_k[i]) begin
                errs++;
                $display("FAIL hold_resume[%0d]: idx=%0d key=%h want %h", i, ridx, rk, exp_k[i]);
            end
            nr = 1'b1;
            tick;
        end
        nr = 1'b0;
        checks++;
        if (done !== 1'b1) begin errs++; $display("FAIL hold_done: got %b want 1", done); end
        tick;
    endtask

    task automatic test_reset_mid;
        logic [63:0] k = rand_key();
        compute_keys(k, 1'b0);
        key = k; dec = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin nr = 1'b1; tick; end
        checks++;
        if (ridx !== 4'd7) begin errs++; $display("FAIL rst_mid_idx7: got %0d want 7", ridx); end
        reset = 1'b1; start = 1'b1; nr = 1'b1;
        tick;
        checks++;
        if ({rkv, done, ridx} !== 6'd0 || rk !== 48'd0) begin
            errs++;
            $display("FAIL rst_mid: valid=%b done=%b idx=%0d key=%h want 0", rkv, done, ridx, rk);
        end
        reset = 1'b0; start = 1'b0; nr = 1'b0;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (rkv !== 1'b1 || ridx !== 4'd0 || rk !== exp_k[0]) begin
            errs++;
            $display("FAIL rst_restart: valid=%b idx=%0d key=%h want 1/0/%h", rkv, ridx, rk, exp_k[0]);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_random;
        logic [63:0] k;
        logic        d;
        int          stalls;
        repeat (6) begin
            k = rand_key();
            d = 1'($urandom_range(0, 1));
            compute_keys(k, d);
            key = k; dec = d; start = 1'b1;
            tick;
            start = 1'b0;
            checks++;
            if (perr !== 1'b0) begin errs++; $display("FAIL rnd_perr: got %b want 0", perr); end
            for (int i = 0; i < 16; i++) begin
                stalls = $urandom_range(0, 2);
                nr = 1'b0;
                repeat (stalls) begin
                    key = {$urandom, $urandom}; dec = ~dec;
                    tick;
                end
                checks++;
                if (rkv !== 1'b1 || ridx !== 4'(i) || rk !== exp_k[i]) begin
                    errs++;
                    $display("FAIL rnd_key[%0d]: valid=%b idx=%0d key=%h want %h",
                             i, rkv, ridx, rk, exp_k[i]);
                end
                if (i == 15) begin start = 1'b1; key = rand_key(); end
                nr = 1'b1;
                tick;
            end
            nr = 1'b0; start = 1'b0;
            checks++;
            if ({done, rkv} !== 2'b10) begin
                errs++; $display("FAIL rnd_done: done/valid=%b want 10", {done, rkv});
            end
            tick;
            checks++;
            if ({done, rkv} !== 2'b00) begin
                errs++; $display("FAIL rnd_final_start: done/valid=%b want 00", {done, rkv});
            end
        end
    endtask

`ifdef DES_KEY_PARITY_CHECK_EN
    task automatic test_parity;
        key = '0; dec = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({perr, rkv} !== 2'b10) begin
            errs++; $display("FAIL parity_err: perr/valid=%b want 10", {perr, rkv});
        end
        tick;
        checks++;
        if ({perr, rkv} !== 2'b00) begin
            errs++; $display("FAIL parity_pulse: perr/valid=%b want 00", {perr, rkv});
        end
        key = KeyStd; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if ({perr, rkv} !== 2'b01 || rk !== KeyK1) begin
            errs++; $display("FAIL parity_ok: perr/valid=%b key=%h", {perr, rkv}, rk);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
    endtask
`endif

    initial begin
        test_reset();
        test_idle_ack_ignored();
        test_known_vector(1'b0);
        test_known_vector(1'b1);
        test_hold_restart();
        test_reset_mid();
        test_random();
`ifdef DES_KEY_PARITY_CHECK_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
